// File: rtl/accum_register.sv
// accum_register: N-bit registered accumulator with load/add/sub/hold, carry in/out,
// sticky overflow, optional saturation and a wrapping operation counter.
module accum_register #(
    parameter int nrOfBits   = 8,
    parameter bit saturate   = 1'b0,
    parameter bit signedMode = 1'b0,
    parameter int countBits  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clockEnable,
    input  logic                 tick,
    input  logic [1:0]           op,
    input  logic                 invertIn,
    input  logic                 carryIn,
    input  logic                 clearSticky,
    input  logic [nrOfBits-1:0]  dataIn,
    output logic [nrOfBits-1:0]  result,
    output logic                 carryOut,
    output logic                 overflow,
    output logic [countBits-1:0] opCount
);
    localparam int fullBits = nrOfBits + 1;
    logic en, isArith, isSub, rawCarry, signedOvf, detect;
    logic [nrOfBits-1:0] operandB, clampValue, nextResult;
    logic [nrOfBits:0] full;
    always_comb begin
        en = clockEnable & tick;
        isArith = op[1];
        isSub = op[0];
        operandB = invertIn ? ~dataIn : dataIn;
        full = isSub ? {1'b0, result} - {1'b0, operandB} - fullBits'(carryIn)
                     : {1'b0, result} + {1'b0, operandB} + fullBits'(carryIn);
        rawCarry = full[nrOfBits];
        // add overflows on equal operand signs, sub on differing ones; either way the sign flipped
        signedOvf = ((result[nrOfBits-1] ^ operandB[nrOfBits-1]) == isSub) &&
                    (full[nrOfBits-1] != result[nrOfBits-1]);
        detect = isArith & (signedMode ? signedOvf : rawCarry);
        // signed overflow always runs away in the direction of the accumulator's sign
        clampValue = signedMode ? {result[nrOfBits-1], {(nrOfBits-1){~result[nrOfBits-1]}}}
                                : {nrOfBits{~isSub}};
        nextResult = (op == 2'b01) ? operandB : (saturate && detect) ? clampValue : full[nrOfBits-1:0];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
            opCount <= '0;
        end else if (en) begin
            overflow <= (overflow & ~clearSticky) | detect;
            if (op != 2'b00) begin
                result <= nextResult;
                carryOut <= isArith & rawCarry;
                opCount <= opCount + countBits'(1);
            end
        end
    end
endmodule

// File: doc/accum_register.md
Name: accum_register

Overview:
- Parametrised successor to the top-level "invert-and-register" path and its small ripple adder.
- Merges both into one N-bit registered arithmetic unit:
  - optional input inversion,
  - load / add / subtract / hold modes,
  - carry in and carry out,
  - sticky overflow,
  - optional saturation,
  - operation counter.
- Instantiated between the ui_in/uio_in pads and the uo_out/uio_out buses of future designs, replacing the discrete register and adder.

Parameters:
- nrOfBits, 8, accumulator/data width (2..32).
- saturate, 0, 1 = clamp result on overflow instead of wrapping.
- signedMode, 0, 1 = overflow and saturation use two's-complement rules; 0 = unsigned.
- countBits, 4, width of the operation counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clockEnable  in  1  update qualifier.
- tick  in  1  second update qualifier (tie 1 if unused); update only when clockEnable & tick.
- op  in  2  00 hold, 01 load, 10 add, 11 subtract.
- invertIn  in  1  1 = operand is ~dataIn.
- carryIn  in  1  carry for add, borrow for subtract.
- clearSticky  in  1  synchronous clear of overflow flag.
- dataIn  in  nrOfBits  operand.
- result  out  nrOfBits  accumulator register.
- carryOut  out  1  registered carry (add) / borrow (sub) of last arithmetic op.
- overflow  out  1  sticky overflow flag.
- opCount  out  countBits  number of non-hold operations performed, wraps.

Behaviour:
- Reset (async, reset=1): result=0, carryOut=0, overflow=0, opCount=0. All outputs held at these values while reset=1, independent of clock.
- en = clockEnable & tick. All state changes on rising clock only when en=1 and reset=0. Latency 1 cycle: result reflects op on the edge where en=1. No combinational input-to-output path.
- Operand B = invertIn ? ~dataIn : dataIn.
- op=00 hold:
  - No register changes, opCount unchanged.
  - clearSticky still honoured when en=1.
- op=01 load:
  - result <= B; carryOut <= 0; opCount += 1.
  - overflow not set by load.
- op=10 add:
  - Full = result + B + carryIn, computed in nrOfBits+1 bits.
  - carryOut <= Full[nrOfBits].
- op=11 subtract:
  - Full = result - B - carryIn, in nrOfBits+1 bits.
  - carryOut <= 1 when a borrow occurred (unsigned result < B + carryIn).
- Overflow detect (arithmetic ops only):
  - signedMode=0: carryOut condition (carry for add, borrow for sub).
  - signedMode=1: operand signs equal (add) or different (sub) and result sign differs from accumulator sign.
- Wrap vs saturate:
  - saturate=0: result <= Full[nrOfBits-1:0].
  - saturate=1 and overflow detected: result <= clamp value. Unsigned clamp: all ones on add, 0 on sub. Signed clamp: max positive (0111..1) or min negative (1000..0), chosen by direction.
  - carryOut still reports the raw carry/borrow when saturating.
- Sticky flag:
  - overflow <= (overflow & ~clearSticky) | detect.
  - clearSticky and detect on the same edge: overflow ends 1 (set wins).
- opCount increments on every en edge with op != 00 and wraps from 2^countBits-1 to 0.
- en=0: all state frozen, including sticky clear.
- Reset asserted mid-sequence clears everything immediately. First update after deassertion occurs on the first rising edge with en=1.

Test Plan (nrOfBits=8, countBits=4 unless noted):
- Reset and load:
  - Assert reset with dataIn=8'h5A → result=0, overflow=0, opCount=0 with no clock edge.
  - Deassert, op=01, invertIn=1, dataIn=8'h0F → after 1 edge result=8'hF0, opCount=1.
- Unsigned add wrap: load 8'hF0; add dataIn=8'h20, carryIn=1 → result=8'h11, carryOut=1, overflow=1.
- Sticky clear: with overflow=1, add dataIn=8'h01 plus clearSticky=1 → overflow=0, result=8'h12.
  - Repeat clearSticky with an overflowing add → overflow remains 1.
- Saturation:
  - saturate=1, signedMode=1: load 8'h70, add 8'h20 → result=8'h7F, overflow=1.
  - Load 8'h80, sub 8'h01 → result=8'h80, overflow=1.
- Enable gating: clockEnable=1, tick=0, op=10 for 5 edges → result and opCount unchanged.
  - Then tick=1 for one edge → one add applied, opCount +1.
- Counter wrap and async reset: perform 16 loads → opCount returns to 0.
  - Assert reset between clock edges mid-stream → all outputs 0 immediately.
